// File: rtl/elevator_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : elevator_dispatcher
// Description : Latches floor requests and drives the car floor by floor in
//               SCAN order, opening the door and retiring each served request.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_dispatcher #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  direction,
    output logic                  moving,
    output logic                  door_open,
    output logic                  served_valid,
    output logic [FLOOR_W-1:0]    served_floor
);

    localparam int TC_W = $clog2(TRAVEL_CYCLES + 1);
    localparam int DC_W = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [TC_W-1:0]         r_travel_cnt, w_travel_cnt_nxt;
    logic [DC_W-1:0]         r_door_cnt, w_door_cnt_nxt;
    logic [NUM_FLOORS-1:0]   w_set, w_clear;
    logic [FLOOR_W-1:0]      w_floor_nxt, w_arrive, w_served_floor_nxt;
    logic                    w_dir_nxt, w_served_nxt, w_door_hold;
    logic [1:0]              w_route;

    // Returns {move, new_direction}; keeps the current direction when idle.
    function automatic logic [1:0] route(input logic [NUM_FLOORS-1:0] pend,
                                         input logic [FLOOR_W-1:0]    floor,
                                         input logic                  dir);
        logic above, below;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend[i] && (i > int'(floor))) above = 1'b1;
            if (pend[i] && (i < int'(floor))) below = 1'b1;
        end
        if (dir) begin
            if (above)      return 2'b11;
            else if (below) return 2'b10;
        end else begin
            if (below)      return 2'b10;
            else if (above) return 2'b11;
        end
        return {1'b0, dir};
    endfunction

    assign w_arrive    = direction ? (current_floor + FLOOR_W'(1))
                                   : (current_floor - FLOOR_W'(1));
    assign w_door_hold = (r_state == S_DOOR) && req_valid && (req_floor == current_floor);

    always_comb begin
        w_state_nxt        = r_state;
        w_travel_cnt_nxt   = r_travel_cnt;
        w_door_cnt_nxt     = r_door_cnt;
        w_floor_nxt        = current_floor;
        w_dir_nxt          = direction;
        w_served_nxt       = 1'b0;
        w_served_floor_nxt = served_floor;
        w_set              = '0;
        w_clear            = '0;
        w_route            = 2'b00;

        if (req_valid && (32'(req_floor) < NUM_FLOORS) && !w_door_hold)
            w_set[req_floor] = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (pending[current_floor]) begin
                    w_state_nxt        = S_DOOR;
                    w_door_cnt_nxt     = '0;
                    w_clear[current_floor] = 1'b1;
                    w_served_nxt       = 1'b1;
                    w_served_floor_nxt = current_floor;
                end else begin
                    w_route          = route(pending, current_floor, direction);
                    w_dir_nxt        = w_route[0];
                    w_travel_cnt_nxt = '0;
                    w_state_nxt      = w_route[1] ? S_MOVE : S_IDLE;
                end
            end
            S_MOVE: begin
                if (r_travel_cnt == TC_W'(TRAVEL_CYCLES - 1)) begin
                    w_floor_nxt      = w_arrive;
                    w_travel_cnt_nxt = '0;
                    if (pending[w_arrive]) begin
                        w_state_nxt        = S_DOOR;
                        w_door_cnt_nxt     = '0;
                        w_clear[w_arrive]  = 1'b1;
                        w_served_nxt       = 1'b1;
                        w_served_floor_nxt = w_arrive;
                    end else begin
                        w_route     = route(pending, w_arrive, direction);
                        w_dir_nxt   = w_route[0];
                        w_state_nxt = w_route[1] ? S_MOVE : S_IDLE;
                    end
                end else begin
                    w_travel_cnt_nxt = r_travel_cnt + TC_W'(1);
                end
            end
            S_DOOR: begin
                // A repeat press of the open floor keeps the door open rather than re-queueing.
                if (w_door_hold) begin
                    w_door_cnt_nxt = '0;
                end else if (r_door_cnt == DC_W'(DOOR_CYCLES - 1)) begin
                    w_door_cnt_nxt   = '0;
                    w_travel_cnt_nxt = '0;
                    w_route          = route(pending, current_floor, direction);
                    w_dir_nxt        = w_route[0];
                    w_state_nxt      = w_route[1] ? S_MOVE : S_IDLE;
                end else begin
                    w_door_cnt_nxt = r_door_cnt + DC_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_travel_cnt  <= '0;
            r_door_cnt    <= '0;
            pending       <= '0;
            current_floor <= '0;
            direction     <= 1'b1;
            moving        <= 1'b0;
            door_open     <= 1'b0;
            served_valid  <= 1'b0;
            served_floor  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_travel_cnt  <= w_travel_cnt_nxt;
            r_door_cnt    <= w_door_cnt_nxt;
            pending       <= (pending | w_set) & ~w_clear;
            current_floor <= w_floor_nxt;
            direction     <= w_dir_nxt;
            moving        <= (w_state_nxt == S_MOVE);
            door_open     <= (w_state_nxt == S_DOOR);
            served_valid  <= w_served_nxt;
            served_floor  <= w_served_floor_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_elevator_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_dispatcher
// Description : Directed scenarios for elevator_dispatcher, compared each
//               cycle against a floor/timer model of the car.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_dispatcher;

    localparam int NF = 8;
    localparam int FW = 3;
    localparam int TC = 4;
    localparam int DC = 3;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [FW-1:0] req_floor = '0;
    logic [NF-1:0] pending;
    logic [FW-1:0] current_floor;
    logic          direction;
    logic          moving;
    logic          door_open;
    logic          served_valid;
    logic [FW-1:0] served_floor;

    int checks = 0;
    int errors = 0;
    int served_q[$];

    elevator_dispatcher #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor),
        .pending(pending), .current_floor(current_floor), .direction(direction),
        .moving(moving), .door_open(door_open), .served_valid(served_valid),
        .served_floor(served_floor)
    );

    always #5 clk = ~clk;

    // Car model: mode plus cycles remaining in that mode.
    typedef struct packed {
        bit [NF-1:0] pend;
        int          floor;
        bit          dir;
        int          mode;
        int          left;
        bit          served;
        int          sfloor;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t reset_state();
        mstate_t r;
        r.pend = '0; r.floor = 0; r.dir = 1'b1; r.mode = M_IDLE;
        r.left = 0; r.served = 1'b0; r.sfloor = 0;
        return r;
    endfunction

    function automatic mstate_t decide(mstate_t n, bit [NF-1:0] pend);
        int  p;
        bit  above, below;
        p     = int'(pend);
        above = (p >> (n.floor + 1)) != 0;
        below = (p % (1 << n.floor)) != 0;
        n.mode = M_IDLE;
        if (n.dir ? above : below) begin
            n.mode = M_MOVE;
        end else if (n.dir ? below : above) begin
            n.mode = M_MOVE;
            n.dir  = !n.dir;
        end
        n.left = TC;
        return n;
    endfunction

    function automatic mstate_t step(mstate_t s, bit rv, int rf);
        mstate_t     n;
        bit [NF-1:0] setm, clrm;
        bit          restart;
        n = s; setm = '0; clrm = '0; restart = 1'b0;
        n.served = 1'b0;
        if (rv && rf < NF) begin
            if (s.mode == M_DOOR && rf == s.floor) restart = 1'b1;
            else setm[rf] = 1'b1;
        end
        if (s.mode == M_IDLE) begin
            if (s.pend[s.floor]) begin
                n.mode = M_DOOR; n.left = DC; clrm[s.floor] = 1'b1;
                n.served = 1'b1; n.sfloor = s.floor;
            end else begin
                n = decide(n, s.pend);
            end
        end else if (s.mode == M_MOVE) begin
            if (s.left > 1) begin
                n.left = s.left - 1;
            end else begin
                n.floor = s.dir ? s.floor + 1 : s.floor - 1;
                if (n.floor >= 0 && n.floor < NF && s.pend[n.floor]) begin
                    n.mode = M_DOOR; n.left = DC; clrm[n.floor] = 1'b1;
                    n.served = 1'b1; n.sfloor = n.floor;
                end else begin
                    n = decide(n, s.pend);
                end
            end
        end else begin
            if (restart)         n.left = DC;
            else if (s.left > 1) n.left = s.left - 1;
            else                 n = decide(n, s.pend);
        end
        n.pend = (s.pend | setm) & ~clrm;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= reset_state();
        else        m <= step(m, req_valid, int'(req_floor));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("pending",       32'(pending),       32'(m.pend));
            chk("current_floor", 32'(current_floor), 32'(m.floor));
            chk("direction",     32'(direction),     32'(m.dir));
            chk("moving",        32'(moving),        32'(m.mode == M_MOVE));
            chk("door_open",     32'(door_open),     32'(m.mode == M_DOOR));
            chk("served_valid",  32'(served_valid),  32'(m.served));
            chk("served_floor",  32'(served_floor),  32'(m.sfloor));
        end
    end

    initial forever begin
        @(posedge clk);
        if (rst_n && served_valid === 1'b1) served_q.push_back(int'(served_floor));
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_req(input int f);
        req_valid = 1'b1;
        req_floor = FW'(f);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (!(pending == '0 && !moving && !door_open) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic wait_served(input int budget);
        int n = 0;
        while (served_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_served: no served_valid within %0d cycles", budget);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n0;
        wait_edges(2);
        rst_n = 1'b1;

        // Idle after reset: nothing moves, nothing is served.
        wait_edges(10);
        chk("idle_pending", 32'(pending), 32'h0);
        chk("idle_floor",   32'(current_floor), 32'h0);
        chk("idle_moving",  32'(moving), 32'h0);
        chk("idle_door",    32'(door_open), 32'h0);
        chk("idle_served",  32'(served_q.size()), 32'h0);

        // Same-floor request twice; second lands on the door-entry edge and is cleared.
        do_req(0);
        chk("f0_latched", 32'(pending), 32'h1);
        do_req(0);
        chk("f0_served",  32'(served_valid), 32'h1);
        chk("f0_sfloor",  32'(served_floor), 32'h0);
        chk("f0_pending", 32'(pending), 32'h0);
        wait_edges(2);
        chk("f0_door_c3", 32'(door_open), 32'h1);
        wait_edges(1);
        chk("f0_door_off", 32'(door_open), 32'h0);

        // Two floors up: one floor per TC cycles.
        do_req(2);
        wait_edges(4);
        chk("f2_still_0", 32'(current_floor), 32'h0);
        chk("f2_moving",  32'(moving), 32'h1);
        wait_edges(1);
        chk("f2_at_1",    32'(current_floor), 32'h1);
        wait_edges(4);
        chk("f2_at_2",    32'(current_floor), 32'h2);
        chk("f2_served",  32'(served_valid), 32'h1);
        chk("f2_sfloor",  32'(served_floor), 32'h2);
        wait_idle(100);
        chk("f2_moving_low", 32'(moving), 32'h0);

        // Pick up floor 3 on the way to 5.
        pulse_reset();
        served_q.delete();
        do_req(5);
        wait_edges(5);
        chk("scan_at_1", 32'(current_floor), 32'h1);
        do_req(3);
        wait_idle(200);
        chk("scan_count", 32'(served_q.size()), 32'd2);
        if (served_q.size() == 2) begin
            chk("scan_first",  32'(served_q[0]), 32'd3);
            chk("scan_second", 32'(served_q[1]), 32'd5);
        end
        chk("scan_dir",   32'(direction), 32'h1);
        chk("scan_floor", 32'(current_floor), 32'd5);

        // Request behind the car waits for the reversal.
        pulse_reset();
        do_req(4);
        wait_idle(200);
        served_q.delete();
        do_req(6);
        do_req(1);
        wait_idle(300);
        chk("rev_count", 32'(served_q.size()), 32'd2);
        if (served_q.size() == 2) begin
            chk("rev_first",  32'(served_q[0]), 32'd6);
            chk("rev_second", 32'(served_q[1]), 32'd1);
        end
        chk("rev_dir",     32'(direction), 32'h0);
        chk("rev_floor",   32'(current_floor), 32'd1);
        chk("rev_pending", 32'(pending), 32'h0);

        // Re-press of the open floor extends the door, single serve.
        n0 = served_q.size();
        do_req(2);
        wait_served(100);
        wait_edges(1);
        do_req(2);
        chk("hold_door",    32'(door_open), 32'h1);
        chk("hold_pending", 32'(pending), 32'h0);
        chk("hold_nosv",    32'(served_valid), 32'h0);
        wait_edges(2);
        chk("hold_door_late", 32'(door_open), 32'h1);
        wait_edges(1);
        chk("hold_door_off",  32'(door_open), 32'h0);
        chk("hold_one_serve", 32'(served_q.size()), 32'(n0 + 1));

        // Asynchronous reset in the middle of travel.
        do_req(6);
        wait_edges(3);
        chk("pre_rst_moving", 32'(moving), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_floor",   32'(current_floor), 32'h0);
        chk("rst_dir",     32'(direction), 32'h1);
        chk("rst_moving",  32'(moving), 32'h0);
        chk("rst_door",    32'(door_open), 32'h0);
        chk("rst_sv",      32'(served_valid), 32'h0);
        chk("rst_sfloor",  32'(served_floor), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(5);
        chk("post_rst_moving", 32'(moving), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elevator_dispatcher.md
Name: elevator_dispatcher

Overview:
- Consumer side of the floor-request bitmap: latches floor requests, moves the car one floor at a time using SCAN order, opens the door at each requested floor, and clears the served request.
- Sits between the request inputs (buttons/decoder) and the car motor/door drivers.
- Exports the pending bitmap and a served-floor strobe so upstream logic can retire requests.

Parameters:
- NUM_FLOORS, 8, number of floors; valid floors are 0..NUM_FLOORS-1.
- FLOOR_W, 3, floor index width; must satisfy 2^FLOOR_W >= NUM_FLOORS.
- TRAVEL_CYCLES, 4, cycles spent in MOVE per one-floor step; must be >= 1.
- DOOR_CYCLES, 3, cycles door_open is held per stop; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request strobe, sampled every rising edge.
- req_floor  in  FLOOR_W  requested floor, qualified by req_valid.
- pending  out  NUM_FLOORS  latched outstanding requests, one bit per floor.
- current_floor  out  FLOOR_W  floor the car is at.
- direction  out  1  1 = up, 0 = down.
- moving  out  1  high while state is MOVE.
- door_open  out  1  high while state is DOOR.
- served_valid  out  1  one-cycle pulse on the first DOOR cycle.
- served_floor  out  FLOOR_W  floor just served; valid with served_valid, holds its value otherwise.

Behaviour:
- Reset (async assert, synchronous release): pending=0, current_floor=0, direction=1, state=IDLE, moving=0, door_open=0, served_valid=0, served_floor=0, counters=0.
- All outputs are registered.
- Request latch:
  - On each edge with req_valid=1 and req_floor<NUM_FLOORS, pending[req_floor] is set.
  - req_floor>=NUM_FLOORS is ignored.
  - A request equal to current_floor while in DOOR is not latched; it restarts the door counter instead (door held DOOR_CYCLES more cycles, no second served_valid).
  - If a set and a clear hit the same bit on the same edge, the clear wins.
- Route decision D (used in IDLE, at DOOR exit, and on each floor arrival):
  - above = any pending bit > current_floor; below = any pending bit < current_floor.
  - If direction=1: above -> MOVE up; else below -> direction=0, MOVE down; else IDLE.
  - If direction=0: below -> MOVE down; else above -> direction=1, MOVE up; else IDLE.
- FSM states: IDLE, MOVE, DOOR.
- IDLE:
  - If pending[current_floor]=1 -> DOOR; this has priority over D.
  - Otherwise apply D.
  - Decisions use registered pending, so a request sampled at edge E is acted on at edge E+1.
- MOVE:
  - The travel counter runs 0..TRAVEL_CYCLES-1.
  - On the edge where it equals TRAVEL_CYCLES-1, current_floor steps by +1 or -1 and the counter resets.
  - At that same edge: if pending[new floor]=1 -> DOOR; else apply D using the new floor.
  - current_floor never leaves 0..NUM_FLOORS-1, because D only moves toward pending bits.
- DOOR entry edge: clear pending[current_floor]; served_valid=1 and served_floor=current_floor for exactly that cycle.
- DOOR:
  - door_open=1 for DOOR_CYCLES cycles, then apply D at the edge where the counter reaches DOOR_CYCLES-1.
  - direction is not changed by a stop.
- Latency: a request for a floor at distance d, sampled at edge E while IDLE, gives served_valid in the cycle following edge E+1+d*TRAVEL_CYCLES.
- Requests arriving mid-travel for floors ahead in the current direction are served on the way (SCAN). Requests behind the car wait until the reversal.
- Reset mid-operation: every register returns to its reset value immediately; pending requests are lost.

Test Plan:
- Reset, then idle 10 cycles -> pending=0, current_floor=0, moving=0, door_open=0, served_valid never asserted.
- At floor 0 IDLE, request floor 0 at edge E -> served_valid with served_floor=0 in the cycle after edge E+1; door_open high 3 cycles; pending returns to 0.
- From floor 0, request floor 2 at edge E -> current_floor=1 after edge E+5, =2 after E+9; served_valid in the cycle after E+9; moving low thereafter.
- Car at 0 moving up to 5, request floor 3 injected while between floors 1 and 2 -> stops at 3 first (served 3, then 5), direction stays 1.
- Car at 4 heading up to 6, request floor 1 latched -> serves 6, then direction=0, descends, serves 1; served sequence 6,1; final pending=0.
- Request floor 2 while door is open at floor 2 -> door_open extended to 3 cycles from that request, one served_valid only; assert rst_n=0 mid-MOVE -> all outputs at reset values in the same cycle.
